// File: rtl/usb_pkg.sv
// Shared encodings for the USB low/full-speed transmitter.
// Holds request codes, PID/SYNC bytes, CRC16 constants and the transmit state enum.
// No logic; constant helpers only.
package usb_pkg;

    // tx_packet request encoding; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_e;

    localparam logic [7:0]  SYNC_BYTE      = 8'h80;
    localparam logic [7:0]  PID_DATA0      = 8'hC3;
    localparam logic [7:0]  PID_DATA1      = 8'h4B;
    localparam logic [7:0]  PID_ACK        = 8'hD2;
    localparam logic [7:0]  PID_NAK        = 8'h5A;
    localparam logic [7:0]  PID_STALL      = 8'h1E;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [6:0]  MAX_DATA_COUNT = 7'd64;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, LOAD, DATA, CRC, EOP_SE0, EOP_J
    } state_e;

    // Bit-reverse, used to turn the MSB-first polynomial into its LSB-first form.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic [7:0] pid_byte(input tx_pkt_e pkt);
        logic [7:0] p;
        case (pkt)
            PKT_DATA0: p = PID_DATA0;
            PKT_DATA1: p = PID_DATA1;
            PKT_ACK:   p = PID_ACK;
            PKT_NAK:   p = PID_NAK;
            PKT_STALL: p = PID_STALL;
            default:   p = 8'h00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16, one payload bit per enabled clock, LSB-first (reflected) form.
// Latency: crc reflects a bit the cycle after bit_en; clr loads the init value next cycle.
// No backpressure; caller strobes bit_en only for real payload bits.
// Ports: clk, n_rst (sync, active-high), clr, bit_en, bit_in -> crc[15:0] (uncomplemented).
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] crc_d, crc_q;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[0] ^ bit_in;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (bit_en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ (fb ? POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) crc_q <= CRC16_INIT;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/usb_tx.sv
// USB packet transmitter: SYNC, PID, payload, CRC16, EOP with NRZI and optional bit stuffing.
// Latency: request accepted in IDLE, first SYNC bit on the line the next cycle.
// Backpressure: requests ignored while busy; payload pulled one byte at a time via get_tx_packet_data.
// Ports: clk, n_rst (sync, active-high); tx_packet/tx_data_count request; tx_packet_data in,
//        get_tx_packet_data out; dplus_out/dminus_out line; tx_transfer_active, tx_error status.
// Build option: define USB_TX_BITSTUFF_EN to insert a stuffed 0 after six consecutive 1s.
module usb_tx
    import usb_pkg::*;
#(
    parameter int BIT_CLKS = 8
)(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] tx_data_count,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);
`ifdef USB_TX_BITSTUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    state_e      state_d, state_q;
    logic [4:0]  bit_cnt_d, bit_cnt_q;   // clock within the current bit time
    logic [4:0]  idx_d, idx_q;           // bit index within the current field
    logic [2:0]  ones_d, ones_q;         // run of transmitted 1s
    logic        lvl_d, lvl_q;           // line level of the previous bit (1 = J)
    logic [7:0]  sr_d, sr_q;             // SYNC/PID/payload byte being sent
    logic [7:0]  byte_d, byte_q;         // prefetched payload byte
    logic [7:0]  pid_d, pid_q;
    logic        hs_d, hs_q;
    logic [6:0]  left_d, left_q;         // payload bytes not yet loaded into sr
    logic        pay_d, pay_q;           // sr holds payload, so its bits feed the CRC
    logic        fetched_d, fetched_q;
    logic        get_dly_d, get_dly_q;
    logic        err_d, err_q;

    tx_pkt_e     req;
    logic        req_data, req_hs, req_bad, accept;
    logic        bit_end, sending, stuff, data_bit, line_lvl, adv, get_pulse;
    logic [15:0] crc;

    assign req      = tx_pkt_e'(tx_packet);
    assign req_data = (req == PKT_DATA0) || (req == PKT_DATA1);
    assign req_hs   = (req == PKT_ACK) || (req == PKT_NAK) || (req == PKT_STALL);
    assign req_bad  = (tx_packet[2:1] == 2'b11) || (req_data && (tx_data_count > MAX_DATA_COUNT));
    assign accept   = (state_q == IDLE) && (req_data || req_hs) && !req_bad;

    assign bit_end  = (bit_cnt_q == 5'(BIT_CLKS - 1));
    assign sending  = (state_q == SYNC) || (state_q == PID) || (state_q == LOAD) ||
                      (state_q == DATA) || (state_q == CRC);
    assign stuff    = STUFF_EN && sending && (ones_q == 3'd6);
    assign data_bit = (state_q == CRC) ? ~crc[idx_q[3:0]] : sr_q[idx_q[2:0]];
    // NRZI: a 0 toggles the level, a 1 (and only a 1) holds it.
    assign line_lvl = (stuff || !data_bit) ? ~lvl_q : lvl_q;
    assign adv      = bit_end && sending && !stuff;
    // LOAD carries the final bit of the preceding field while the next byte is fetched,
    // so the byte is in byte_q before DATA needs it and the bit stream has no gap.
    assign get_pulse = (state_q == LOAD) && !fetched_q;

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (accept),
        .bit_en (adv && pay_q && ((state_q == DATA) || (state_q == LOAD))),
        .bit_in (data_bit),
        .crc    (crc)
    );

    always_comb begin
        ones_d = ones_q;
        if (state_q == IDLE) begin
            ones_d = 3'd0;
        end else if (sending && bit_end) begin
            if (stuff || !data_bit)     ones_d = 3'd0;
            else if (ones_q != 3'd6)    ones_d = ones_q + 3'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_end ? 5'd0 : bit_cnt_q + 5'd1;
        idx_d     = idx_q;
        lvl_d     = (sending && bit_end) ? line_lvl : lvl_q;
        sr_d      = sr_q;
        byte_d    = get_dly_q ? tx_packet_data : byte_q;
        pid_d     = pid_q;
        hs_d      = hs_q;
        left_d    = left_q;
        pay_d     = pay_q;
        fetched_d = fetched_q | get_pulse;
        get_dly_d = get_pulse;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 5'd0;
                idx_d     = 5'd0;
                lvl_d     = 1'b1;
                err_d     = req_bad;
                if (accept) begin
                    state_d   = SYNC;
                    sr_d      = SYNC_BYTE;
                    pid_d     = pid_byte(req);
                    hs_d      = req_hs;
                    left_d    = tx_data_count;
                    pay_d     = 1'b0;
                    fetched_d = 1'b0;
                end
            end
            SYNC: if (adv) begin
                if (idx_q == 5'd7) begin
                    state_d = PID;
                    idx_d   = 5'd0;
                    sr_d    = pid_q;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            PID, DATA: if (adv) begin
                if (idx_q == 5'd7) begin
                    state_d = (state_q == PID && hs_q) ? EOP_SE0 : CRC;
                    idx_d   = 5'd0;
                    pay_d   = 1'b0;
                end else begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd6 && !hs_q && left_q != 7'd0) state_d = LOAD;
                end
            end
            LOAD: if (adv) begin
                state_d   = DATA;
                idx_d     = 5'd0;
                sr_d      = byte_q;
                pay_d     = 1'b1;
                left_d    = left_q - 7'd1;
                fetched_d = 1'b0;
            end
            CRC: begin
                // idx 16 is a tail slot holding the stuffed 0 a CRC ending in six 1s needs.
                if (bit_end && stuff && idx_q == 5'd16) begin
                    state_d = EOP_SE0;
                    idx_d   = 5'd0;
                end else if (adv) begin
                    if (idx_q == 5'd15 && !(STUFF_EN && ones_d == 3'd6)) begin
                        state_d = EOP_SE0;
                        idx_d   = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            EOP_SE0: if (bit_end) begin
                if (idx_q == 5'd1) begin
                    state_d = EOP_J;
                    idx_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            EOP_J: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            idx_q     <= 5'd0;
            ones_q    <= 3'd0;
            lvl_q     <= 1'b1;
            sr_q      <= 8'h00;
            byte_q    <= 8'h00;
            pid_q     <= 8'h00;
            hs_q      <= 1'b0;
            left_q    <= 7'd0;
            pay_q     <= 1'b0;
            fetched_q <= 1'b0;
            get_dly_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            ones_q    <= ones_d;
            lvl_q     <= lvl_d;
            sr_q      <= sr_d;
            byte_q    <= byte_d;
            pid_q     <= pid_d;
            hs_q      <= hs_d;
            left_q    <= left_d;
            pay_q     <= pay_d;
            fetched_q <= fetched_d;
            get_dly_q <= get_dly_d;
            err_q     <= err_d;
        end
    end

    assign dplus_out          = (state_q == EOP_SE0) ? 1'b0 : (sending ? line_lvl  : 1'b1);
    assign dminus_out         = (state_q == EOP_SE0) ? 1'b0 : (sending ? ~line_lvl : 1'b0);
    assign tx_transfer_active = (state_q != IDLE);
    assign get_tx_packet_data = get_pulse;
    assign tx_error           = err_q;
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: vector table plus reset-abort sequence.
// Expected line waveforms come from a bench-side NRZI/stuffing/CRC model (MSB-first CRC form).
module tb_usb_tx;
    localparam int BC = 8;
`ifdef USB_TX_BITSTUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [6:0] tx_data_count;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data, dplus_out, dminus_out, tx_transfer_active, tx_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_tx #(.BIT_CLKS(BC)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_data_count      (tx_data_count),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    typedef struct {
        logic [2:0]  pkt;
        int          cnt;
        logic [23:0] bytes;      // byte k in bits [8k+7:8k]
        logic [2:0]  busy_pkt;   // request driven mid-packet, must be ignored
        int          exp_err;
        int          exp_gets;
        int          clks_plain;
        int          clks_stuff;
        string       name;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    logic [1:0] exp_q[$];   // expected {dplus,dminus} per active clock

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_model(input logic [2:0] pkt, input int cnt, input logic [23:0] bytes);
        bit          raw[$];
        logic [7:0]  sync_b, pid;
        logic [15:0] crc;
        bit          d, fb, line;
        int          ones;
        exp_q.delete();
        sync_b = 8'h80;
        case (pkt)
            3'd1: pid = 8'hC3;
            3'd2: pid = 8'h4B;
            3'd3: pid = 8'hD2;
            3'd4: pid = 8'h5A;
            3'd5: pid = 8'h1E;
            default: pid = 8'h00;
        endcase
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
        if (pkt == 3'd1 || pkt == 3'd2) begin
            crc = 16'hFFFF;
            for (int k = 0; k < cnt; k++) begin
                for (int i = 0; i < 8; i++) begin
                    d = bytes[8*k+i];
                    raw.push_back(d);
                    fb  = crc[15] ^ d;
                    crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            end
            crc = ~crc;
            for (int i = 15; i >= 0; i--) raw.push_back(crc[i]);
        end
        line = 1'b1;
        ones = 0;
        for (int j = 0; j < raw.size(); j++) begin
            if (!raw[j]) line = ~line;
            repeat (BC) exp_q.push_back({line, ~line});
            ones = raw[j] ? ones + 1 : 0;
            if (STUFF && ones == 6) begin
                line = ~line;
                repeat (BC) exp_q.push_back({line, ~line});
                ones = 0;
            end
        end
        repeat (2*BC) exp_q.push_back(2'b00);
        repeat (BC)   exp_q.push_back(2'b10);
    endtask

    task automatic do_vec(input vec_t v);
        logic [1:0] got[$];
        int clks, gets, errs, idle_bad, mism, cyc, quiet, k, restart;
        bit timed_out;
        clks = 0; gets = 0; errs = 0; idle_bad = 0; mism = 0;
        cyc = 0; quiet = 0; k = 0; restart = 0; timed_out = 1'b1;
        if (v.exp_err != 0) exp_q.delete();
        else build_model(v.pkt, v.cnt, v.bytes);
        tx_packet     = v.pkt;
        tx_data_count = 7'(v.cnt);
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1)  tx_packet = 3'd0;
            if (cyc == 40) tx_packet = v.busy_pkt;
            if (cyc == 41) tx_packet = 3'd0;
            if (tx_error) errs++;
            if (get_tx_packet_data) begin
                gets++;
                if (k < 3) tx_packet_data = v.bytes[8*k +: 8];
                k++;
            end
            if (tx_transfer_active) begin
                clks++;
                got.push_back({dplus_out, dminus_out});
            end else begin
                if ({dplus_out, dminus_out} != 2'b10) idle_bad++;
                quiet++;
                if (clks > 0 || quiet >= 8) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_transfer_active || tx_error) restart++;
            if ({dplus_out, dminus_out} != 2'b10) idle_bad++;
        end
        for (int j = 0; j < got.size() && j < exp_q.size(); j++)
            if (got[j] !== exp_q[j]) mism++;
        check({v.name, " completion"},       int'(timed_out), 0);
        check({v.name, " tx_error pulses"},  errs, v.exp_err);
        check({v.name, " get pulses"},       gets, v.exp_gets);
        check({v.name, " active clocks"},    clks, STUFF ? v.clks_stuff : v.clks_plain);
        check({v.name, " line length"},      got.size(), exp_q.size());
        check({v.name, " line mismatches"},  mism, 0);
        check({v.name, " idle not J"},       idle_bad, 0);
        check({v.name, " restart after end"}, restart, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, cyc;
        //         pkt   cnt bytes      busy  err gets plain stuff name
        vecs[0] = '{3'd3, 0, 24'h0,     3'd1, 0,  0,   152,  152, "ack"};
        vecs[1] = '{3'd4, 0, 24'h0,     3'd5, 0,  0,   152,  152, "nak"};
        vecs[2] = '{3'd5, 0, 24'h0,     3'd6, 0,  0,   152,  152, "stall"};
        vecs[3] = '{3'd1, 0, 24'h0,     3'd2, 0,  0,   280,  280, "data0_len0"};
        vecs[4] = '{3'd2, 2, 24'hFFFF,  3'd3, 0,  2,   408,  448, "data1_ff_ff"};
        vecs[5] = '{3'd1, 1, 24'hFF,    3'd4, 0,  1,   344,  360, "data0_ff"};
        vecs[6] = '{3'd2, 1, 24'h00,    3'd1, 0,  1,   344,  352, "data1_00"};
        vecs[7] = '{3'd6, 0, 24'h0,     3'd0, 1,  0,   0,    0,   "illegal6"};
        vecs[8] = '{3'd7, 0, 24'h0,     3'd0, 1,  0,   0,    0,   "illegal7"};
        vecs[9] = '{3'd1, 65, 24'h0,    3'd0, 1,  0,   0,    0,   "count65"};

        n_rst = 1'b1;
        tx_packet = 3'd0;
        tx_data_count = 7'd0;
        tx_packet_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset dplus",  int'(dplus_out), 1);
        check("reset dminus", int'(dminus_out), 0);
        check("reset active", int'(tx_transfer_active), 0);
        check("reset get",    int'(get_tx_packet_data), 0);
        check("reset error",  int'(tx_error), 0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) do_vec(vecs[i]);

        // Reset in the middle of a payload byte.
        tx_packet = 3'd1;
        tx_data_count = 7'd3;
        seen = 0;
        cyc = 0;
        while (cyc < 1000 && seen < 2) begin
            @(posedge clk); #1;
            cyc++;
            tx_packet = 3'd0;
            if (get_tx_packet_data) begin
                seen++;
                tx_packet_data = 8'hA5;
            end
        end
        check("abort reached second byte", seen, 2);
        repeat (12) @(posedge clk);
        #1;
        check("abort active before reset", int'(tx_transfer_active), 1);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("abort dplus",  int'(dplus_out), 1);
        check("abort dminus", int'(dminus_out), 0);
        check("abort active", int'(tx_transfer_active), 0);
        check("abort get",    int'(get_tx_packet_data), 0);
        n_rst = 1'b0;
        @(posedge clk); #1;
        do_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
